// File: rtl/nw_job_scheduler.sv
// rtl/nw_job_scheduler.sv - round-robin job scheduler sharing one alignment grid between NREQ requesters
// Optional feature macro: NW_SCHED_STATS_EN adds stat_jobs, stat_timeouts and stat_last_cycles outputs.
module nw_job_scheduler #(
    parameter int LENGTH       = 10,
    parameter int CWIDTH       = 2,
    parameter int SWIDTH       = 16,
    parameter int NREQ         = 4,
    parameter int IDW          = 2,
    parameter int CLEAR_CYCLES = 2,
    parameter int MAX_CYCLES   = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]   req_s1,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]   req_s2,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [IDW-1:0]                  rsp_id,
    output logic signed [SWIDTH-1:0]        rsp_score,
    output logic                            rsp_timeout,
    output logic                            grid_reset,
    output logic [LENGTH*CWIDTH-1:0]        grid_s1,
    output logic [LENGTH*CWIDTH-1:0]        grid_s2,
    input  logic signed [SWIDTH-1:0]        grid_score,
    input  logic                            grid_valid,
    output logic                            busy
`ifdef NW_SCHED_STATS_EN
    ,
    output logic [15:0]                     stat_jobs,
    output logic [7:0]                      stat_timeouts,
    output logic [7:0]                      stat_last_cycles
`endif
);

    localparam int SW  = LENGTH * CWIDTH;
    localparam int TOW = 8;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

    state_t                   r_state;
    logic [IDW-1:0]           r_rr;
    logic [TOW-1:0]           r_cnt;
    logic                     r_grid_reset;
    logic [SW-1:0]            r_grid_s1;
    logic [SW-1:0]            r_grid_s2;
    logic                     r_rsp_valid;
    logic [IDW-1:0]           r_rsp_id;
    logic signed [SWIDTH-1:0] r_rsp_score;
    logic                     r_rsp_timeout;

    logic                     w_found;
    logic [IDW-1:0]           w_gid;
    logic [IDW-1:0]           w_rr_next;
    logic [NREQ-1:0]          w_req_ready;
    int                       w_idx;

`ifdef NW_SCHED_STATS_EN
    logic [TOW-1:0]           r_run_cycles;
    logic [15:0]              r_stat_jobs;
    logic [7:0]               r_stat_timeouts;
    logic [TOW-1:0]           r_stat_last_cycles;
`endif

    // Round-robin search: first requesting index at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = IDW'(w_idx);
            end
        end
    end

    assign w_rr_next   = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
    // Grant is only offered while idle, so a response handshake cycle never accepts a job.
    assign w_req_ready = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_gid) : '0;

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_score   = r_rsp_score;
    assign rsp_timeout = r_rsp_timeout;
    assign grid_reset  = r_grid_reset;
    assign grid_s1     = r_grid_s1;
    assign grid_s2     = r_grid_s2;
    assign busy        = (r_state != S_IDLE);

`ifdef NW_SCHED_STATS_EN
    assign stat_jobs        = r_stat_jobs;
    assign stat_timeouts    = r_stat_timeouts;
    assign stat_last_cycles = r_stat_last_cycles;
`endif

    // Job sequencer: accept, hold the grid in reset, run it to completion or timeout, then hand back the result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rr          <= '0;
            r_cnt         <= '0;
            r_grid_reset  <= 1'b1;
            r_grid_s1     <= '0;
            r_grid_s2     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_score   <= '0;
            r_rsp_timeout <= 1'b0;
`ifdef NW_SCHED_STATS_EN
            r_run_cycles       <= '0;
            r_stat_jobs        <= '0;
            r_stat_timeouts    <= '0;
            r_stat_last_cycles <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_grid_reset <= 1'b1;
                    if (w_found) begin
                        r_grid_s1 <= req_s1[int'(w_gid) * SW +: SW];
                        r_grid_s2 <= req_s2[int'(w_gid) * SW +: SW];
                        r_rsp_id  <= w_gid;
                        r_rr      <= w_rr_next;
                        r_cnt     <= '0;
                        r_state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == TOW'(CLEAR_CYCLES - 1)) begin
                        r_cnt        <= '0;
                        r_grid_reset <= 1'b0;
                        r_state      <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A valid arriving on the last allowed cycle still counts as a real result.
                    if (grid_valid || r_cnt == TOW'(MAX_CYCLES - 1)) begin
                        r_rsp_score   <= grid_valid ? grid_score : '0;
                        r_rsp_timeout <= !grid_valid;
                        r_rsp_valid   <= 1'b1;
                        r_grid_reset  <= 1'b1;
                        r_state       <= S_RESP;
`ifdef NW_SCHED_STATS_EN
                        r_run_cycles  <= r_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
`ifdef NW_SCHED_STATS_EN
                        r_stat_jobs        <= r_stat_jobs + 16'd1;
                        r_stat_last_cycles <= r_run_cycles;
                        if (r_rsp_timeout && r_stat_timeouts != 8'hFF) begin
                            r_stat_timeouts <= r_stat_timeouts + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nw_job_scheduler.sv
// tb/tb_nw_job_scheduler.sv - table-driven bench for nw_job_scheduler with a toy grid model
module tb_nw_job_scheduler;

    localparam int LENGTH = 10;
    localparam int CWIDTH = 2;
    localparam int SWIDTH = 16;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int SW     = LENGTH * CWIDTH;
    localparam int CLR    = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*SW-1:0]       req_s1;
    logic [NREQ*SW-1:0]       req_s2;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic signed [SWIDTH-1:0] rsp_score;
    logic                     rsp_timeout;
    logic                     grid_reset;
    logic [SW-1:0]            grid_s1;
    logic [SW-1:0]            grid_s2;
    logic signed [SWIDTH-1:0] grid_score;
    logic                     grid_valid;
    logic                     busy;
`ifdef NW_SCHED_STATS_EN
    logic [15:0]              stat_jobs;
    logic [7:0]               stat_timeouts;
    logic [7:0]               stat_last_cycles;
`endif

    int n_pass  = 0;
    int n_total = 0;

    nw_job_scheduler #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .NREQ(NREQ), .IDW(IDW),
        .CLEAR_CYCLES(CLR), .MAX_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_s1(req_s1), .req_s2(req_s2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_score(rsp_score), .rsp_timeout(rsp_timeout),
        .grid_reset(grid_reset), .grid_s1(grid_s1), .grid_s2(grid_s2),
        .grid_score(grid_score), .grid_valid(grid_valid), .busy(busy)
`ifdef NW_SCHED_STATS_EN
        , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts), .stat_last_cycles(stat_last_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Toy grid: +1 per matching character, -1 per mismatch; valid g_delay cycles after reset drops.
    int       g_delay = 0;
    logic [7:0] g_cnt;

    function automatic logic signed [15:0] toy_score(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic signed [15:0] s;
        s = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (a[k*CWIDTH +: CWIDTH] == b[k*CWIDTH +: CWIDTH]) s = s + 16'sd1;
            else s = s - 16'sd1;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (grid_reset) g_cnt <= 8'd0;
        else if (g_cnt != 8'hFF) g_cnt <= g_cnt + 8'd1;
    end

    assign grid_valid = !grid_reset && (int'(g_cnt) >= g_delay);
    assign grid_score = toy_score(grid_s1, grid_s2);

    typedef struct {
        logic [NREQ-1:0] rv;
        logic [IDW-1:0]  id;
        logic [SW-1:0]   s1;
        logic [SW-1:0]   s2;
        int              delay;
        int              score;
        logic            to;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Requested slice carries the vector strings; other slices carry all-mismatch filler.
    task automatic apply_req(input vec_t v);
        for (int i = 0; i < NREQ; i++) begin
            if (i == int'(v.id)) begin
                req_s1[i*SW +: SW] = v.s1;
                req_s2[i*SW +: SW] = v.s2;
            end else begin
                req_s1[i*SW +: SW] = '0;
                req_s2[i*SW +: SW] = '1;
            end
        end
        req_valid = v.rv;
        g_delay   = v.delay;
    endtask

    task automatic run_job(input vec_t v, input int bp_cycles);
        int n;
        int clr;
        int exp_lat;
        bit ok;
        @(negedge clk);
        apply_req(v);
        #1;
        n = 0;
        while (!(|(req_valid & req_ready)) && n < 10) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (n >= 10) begin
            check("accept_wait", 0, 1);
            req_valid = '0;
            return;
        end
        check("req_ready", req_ready, longint'(4'b0001 << v.id));
        @(posedge clk); #1;
        req_valid = '0;
        req_s1 = '1;
        req_s2 = '0;
        @(negedge clk);
        check("busy", busy, 1);
        n = 0; clr = 0;
        while (!rsp_valid && n < 200) begin
            if (grid_reset && n == clr) clr++;
            @(posedge clk); @(negedge clk); n++;
        end
        exp_lat = CLR + ((v.delay < 64) ? v.delay + 1 : 64);
        check("clear_cycles", clr, CLR);
        check("latency", n, exp_lat);
        check("rsp_id", rsp_id, v.id);
        check("rsp_score", rsp_score, v.score);
        check("rsp_timeout", rsp_timeout, v.to);
        if (bp_cycles > 0) begin
            req_valid = 4'b1111;
            for (int c = 0; c < bp_cycles; c++) begin
                @(posedge clk); @(negedge clk);
                ok = rsp_valid && (rsp_id == v.id) && (int'(rsp_score) == v.score) && (req_ready == '0);
                check("bp_hold", ok, 1);
            end
            rsp_ready = 1'b1;
            #1;
            check("no_accept_in_handshake", req_ready, 0);
            @(posedge clk); @(negedge clk);
            check("rsp_valid_drop", rsp_valid, 0);
            check("next_grant", req_ready, longint'(4'b0001 << (v.id + 2'd1)));
            req_valid = '0;
        end else begin
            @(posedge clk); @(negedge clk);
            check("rsp_valid_drop", rsp_valid, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   saw;
        tbl[0] = '{4'b0100, 2'd2, 20'h00000, 20'h00000,  5,  10, 1'b0};
        tbl[1] = '{4'b1111, 2'd3, 20'h55555, 20'hAAAAA,  0, -10, 1'b0};
        tbl[2] = '{4'b1111, 2'd0, 20'h00000, 20'h0003F, 12,   4, 1'b0};
        tbl[3] = '{4'b1111, 2'd1, 20'hABCDE, 20'hABCDE, 63,  10, 1'b0};
        tbl[4] = '{4'b1111, 2'd2, 20'h12345, 20'h54321, 64,   0, 1'b1};
        tbl[5] = '{4'b1111, 2'd3, 20'h12345, 20'h12345,  1,  10, 1'b0};
        tbl[6] = '{4'b1111, 2'd0, 20'hFFFFF, 20'hFFFFF,  2,  10, 1'b0};
        tbl[7] = '{4'b1001, 2'd3, 20'h00000, 20'h0003F,  7,   4, 1'b0};
        tbl[8] = '{4'b0010, 2'd1, 20'h55555, 20'h55555, 30,  10, 1'b0};

        reset = 1'b0; req_valid = '0; req_s1 = '0; req_s2 = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grid_reset", grid_reset, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_score", rsp_score, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_grid_s", {grid_s1, grid_s2}, 0);
        check("rst_busy", busy, 0);
`ifdef NW_SCHED_STATS_EN
        check("rst_stats", {stat_jobs, stat_timeouts, stat_last_cycles}, 0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_job(tbl[i], 0);
`ifdef NW_SCHED_STATS_EN
            if (i == 4) begin
                check("stat_jobs", stat_jobs, 5);
                check("stat_timeouts", stat_timeouts, 1);
                check("stat_last_cycles", stat_last_cycles, 64);
            end
`endif
        end

        // Back-pressure on the response channel: pointer is 2, only requester 0 asks.
        rsp_ready = 1'b0;
        v = '{4'b0001, 2'd0, 20'h00000, 20'h00000, 3, 10, 1'b0};
        run_job(v, 20);

        // Reset in the middle of a run aborts silently and resets the pointer.
        @(negedge clk);
        v = '{4'b0001, 2'd0, 20'h00000, 20'h00000, 40, 10, 1'b0};
        apply_req(v);
        #1;
        check("abort_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(negedge clk);
        check("abort_in_run", grid_reset, 0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_grid_reset", grid_reset, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        saw = 1'b0;
        repeat (70) begin
            @(negedge clk);
            saw = saw | rsp_valid;
        end
        check("abort_no_rsp", saw, 0);
        v = '{4'b0011, 2'd0, 20'h00000, 20'h0003F, 4, 4, 1'b0};
        run_job(v, 0);
`ifdef NW_SCHED_STATS_EN
        check("stat_jobs_after_abort", stat_jobs, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
